// File: rtl/idex_stage_if.sv
// ID/EX stage bundle: ID-side decode and control, WB bypass port, pipeline controls and registered EX-side copies.
interface idex_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    // Pipeline control
    logic             hold;
    logic             flush_EX;
    logic             stall_IFID;

    // ID-side instruction
    logic             valid_ID;
    logic [XLEN-1:0]  pc_ID;
    logic [XLEN-1:0]  imm_ID;
    logic [4:0]       rs1_ID;
    logic [4:0]       rs2_ID;
    logic [4:0]       rd_ID;
    logic             uses_rs1_ID;
    logic             uses_rs2_ID;
    logic [XLEN-1:0]  rdata1_ID;
    logic [XLEN-1:0]  rdata2_ID;
    logic             RegWrite_ID;
    logic             MemRead_ID;
    logic             MemWrite_ID;
    logic             MemtoReg_ID;
    logic             ALUSrc_ID;
    logic [3:0]       ALUOp_ID;

    // WB write port seen by ID
    logic             RegWrite_MEWB;
    logic [4:0]       rd_MEWB;
    logic [XLEN-1:0]  wdata_MEWB;

    // Registered EX-side copies
    logic             valid_IDEX;
    logic [XLEN-1:0]  pc_IDEX;
    logic [XLEN-1:0]  imm_IDEX;
    logic [4:0]       rs1_IDEX;
    logic [4:0]       rs2_IDEX;
    logic [4:0]       rd_IDEX;
    logic [XLEN-1:0]  rdata1_IDEX;
    logic [XLEN-1:0]  rdata2_IDEX;
    logic             RegWrite_IDEX;
    logic             MemRead_IDEX;
    logic             MemWrite_IDEX;
    logic             MemtoReg_IDEX;
    logic             ALUSrc_IDEX;
    logic [3:0]       ALUOp_IDEX;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output hold, flush_EX, valid_ID, pc_ID, imm_ID, rs1_ID, rs2_ID, rd_ID,
               uses_rs1_ID, uses_rs2_ID, rdata1_ID, rdata2_ID,
               RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, ALUOp_ID,
               RegWrite_MEWB, rd_MEWB, wdata_MEWB,
        input  stall_IFID, valid_IDEX, pc_IDEX, imm_IDEX, rs1_IDEX, rs2_IDEX, rd_IDEX,
               rdata1_IDEX, rdata2_IDEX, RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX,
               MemtoReg_IDEX, ALUSrc_IDEX, ALUOp_IDEX, bubble_cnt
    );

    modport slave (
        input  hold, flush_EX, valid_ID, pc_ID, imm_ID, rs1_ID, rs2_ID, rd_ID,
               uses_rs1_ID, uses_rs2_ID, rdata1_ID, rdata2_ID,
               RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, ALUOp_ID,
               RegWrite_MEWB, rd_MEWB, wdata_MEWB,
        output stall_IFID, valid_IDEX, pc_IDEX, imm_IDEX, rs1_IDEX, rs2_IDEX, rd_IDEX,
               rdata1_IDEX, rdata2_IDEX, RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX,
               MemtoReg_IDEX, ALUSrc_IDEX, ALUOp_IDEX, bubble_cnt
    );
endinterface

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, WB->ID operand bypass
// and a saturating count of inserted bubbles.
module idex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    idex_stage_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             valid_q,    valid_d;
    logic [XLEN-1:0]  pc_q,       pc_d;
    logic [XLEN-1:0]  imm_q,      imm_d;
    logic [4:0]       rs1_q,      rs1_d;
    logic [4:0]       rs2_q,      rs2_d;
    logic [4:0]       rd_q,       rd_d;
    logic [XLEN-1:0]  rdata1_q,   rdata1_d;
    logic [XLEN-1:0]  rdata2_q,   rdata2_d;
    logic             regwrite_q, regwrite_d;
    logic             memread_q,  memread_d;
    logic             memwrite_q, memwrite_d;
    logic             memtoreg_q, memtoreg_d;
    logic             alusrc_q,   alusrc_d;
    logic [3:0]       aluop_q,    aluop_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic             lu_c;
    logic             byp1_c;
    logic             byp2_c;

    // Hazard and bypass detection against the instruction currently held for EX
    always_comb begin
        lu_c   = bus.valid_ID & valid_q & memread_q & (rd_q != 5'd0) &
                 ((bus.uses_rs1_ID & (bus.rs1_ID == rd_q)) |
                  (bus.uses_rs2_ID & (bus.rs2_ID == rd_q)));
        byp1_c = bus.RegWrite_MEWB & (bus.rd_MEWB != 5'd0) & (bus.rd_MEWB == bus.rs1_ID);
        byp2_c = bus.RegWrite_MEWB & (bus.rd_MEWB != 5'd0) & (bus.rd_MEWB == bus.rs2_ID);
    end

    // Next state: hold freezes, flush or load-use inserts a bubble, otherwise capture ID
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        rdata1_d   = rdata1_q;
        rdata2_d   = rdata2_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        memtoreg_d = memtoreg_q;
        alusrc_d   = alusrc_q;
        aluop_d    = aluop_q;
        cnt_d      = cnt_q;
        if (!bus.hold) begin
            if (bus.flush_EX || lu_c) begin
                valid_d    = 1'b0;
                pc_d       = '0;
                imm_d      = '0;
                rs1_d      = 5'd0;
                rs2_d      = 5'd0;
                rd_d       = 5'd0;
                rdata1_d   = '0;
                rdata2_d   = '0;
                regwrite_d = 1'b0;
                memread_d  = 1'b0;
                memwrite_d = 1'b0;
                memtoreg_d = 1'b0;
                alusrc_d   = 1'b0;
                aluop_d    = 4'd0;
                // Only a real instruction displaced by the bubble is counted
                if (bus.valid_ID && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                valid_d    = bus.valid_ID;
                pc_d       = bus.pc_ID;
                imm_d      = bus.imm_ID;
                rs1_d      = bus.rs1_ID;
                rs2_d      = bus.rs2_ID;
                rd_d       = bus.rd_ID;
                rdata1_d   = byp1_c ? bus.wdata_MEWB : bus.rdata1_ID;
                rdata2_d   = byp2_c ? bus.wdata_MEWB : bus.rdata2_ID;
                regwrite_d = bus.RegWrite_ID;
                memread_d  = bus.MemRead_ID;
                memwrite_d = bus.MemWrite_ID;
                memtoreg_d = bus.MemtoReg_ID;
                alusrc_d   = bus.ALUSrc_ID;
                aluop_d    = bus.ALUOp_ID;
            end
        end
    end

    // Pipeline register and bubble counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            imm_q      <= '0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rd_q       <= 5'd0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            alusrc_q   <= 1'b0;
            aluop_q    <= 4'd0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            rdata1_q   <= rdata1_d;
            rdata2_q   <= rdata2_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
            alusrc_q   <= alusrc_d;
            aluop_q    <= aluop_d;
            cnt_q      <= cnt_d;
        end
    end

    // Stall is suppressed by a flush (instruction dies anyway) and by hold (already frozen)
    assign bus.stall_IFID    = lu_c & ~bus.flush_EX & ~bus.hold;

    assign bus.valid_IDEX    = valid_q;
    assign bus.pc_IDEX       = pc_q;
    assign bus.imm_IDEX      = imm_q;
    assign bus.rs1_IDEX      = rs1_q;
    assign bus.rs2_IDEX      = rs2_q;
    assign bus.rd_IDEX       = rd_q;
    assign bus.rdata1_IDEX   = rdata1_q;
    assign bus.rdata2_IDEX   = rdata2_q;
    assign bus.RegWrite_IDEX = regwrite_q;
    assign bus.MemRead_IDEX  = memread_q;
    assign bus.MemWrite_IDEX = memwrite_q;
    assign bus.MemtoReg_IDEX = memtoreg_q;
    assign bus.ALUSrc_IDEX   = alusrc_q;
    assign bus.ALUOp_IDEX    = aluop_q;
    assign bus.bubble_cnt    = cnt_q;
endmodule

// File: tb/tb_idex_stage.sv
// Bench for idex_stage: directed scenarios plus random traffic against a behavioural model.
module tb_idex_stage;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    idex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    idex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Expected EX-side view of the pipeline
    logic        m_valid, m_rw, m_mr, m_mw, m_m2r, m_as;
    logic [31:0] m_pc, m_imm, m_rd1, m_rd2;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [3:0]  m_aluop;
    int          m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_as = 0;
        m_pc = 0; m_imm = 0; m_rd1 = 0; m_rd2 = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_aluop = 0; m_cnt = 0;
    endtask

    // Does the ID instruction read a register the load in EX has yet to produce?
    function automatic logic model_lu();
        logic reads_dest;
        reads_dest = (bus.uses_rs1_ID && bus.rs1_ID == m_rd) ||
                     (bus.uses_rs2_ID && bus.rs2_ID == m_rd);
        return bus.valid_ID && m_valid && m_mr && (m_rd != 0) && reads_dest;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
        if (bus.RegWrite_MEWB && bus.rd_MEWB != 0 && bus.rd_MEWB == rs) return bus.wdata_MEWB;
        return rf;
    endfunction

    task automatic model_step();
        logic lu;
        lu = model_lu();
        if (bus.hold) return;
        if (bus.flush_EX || lu) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_as = 0;
            m_pc = 0; m_imm = 0; m_rd1 = 0; m_rd2 = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_aluop = 0;
            if (bus.valid_ID && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end else begin
            m_valid = bus.valid_ID;  m_pc = bus.pc_ID;   m_imm = bus.imm_ID;
            m_rs1 = bus.rs1_ID;      m_rs2 = bus.rs2_ID; m_rd = bus.rd_ID;
            m_rd1 = operand(bus.rs1_ID, bus.rdata1_ID);
            m_rd2 = operand(bus.rs2_ID, bus.rdata2_ID);
            m_rw = bus.RegWrite_ID;  m_mr = bus.MemRead_ID; m_mw = bus.MemWrite_ID;
            m_m2r = bus.MemtoReg_ID; m_as = bus.ALUSrc_ID;  m_aluop = bus.ALUOp_ID;
        end
    endtask

    task automatic check_all();
        chk("valid_IDEX",    64'(bus.valid_IDEX),    64'(m_valid));
        chk("pc_IDEX",       64'(bus.pc_IDEX),       64'(m_pc));
        chk("imm_IDEX",      64'(bus.imm_IDEX),      64'(m_imm));
        chk("rs1_IDEX",      64'(bus.rs1_IDEX),      64'(m_rs1));
        chk("rs2_IDEX",      64'(bus.rs2_IDEX),      64'(m_rs2));
        chk("rd_IDEX",       64'(bus.rd_IDEX),       64'(m_rd));
        chk("rdata1_IDEX",   64'(bus.rdata1_IDEX),   64'(m_rd1));
        chk("rdata2_IDEX",   64'(bus.rdata2_IDEX),   64'(m_rd2));
        chk("RegWrite_IDEX", 64'(bus.RegWrite_IDEX), 64'(m_rw));
        chk("MemRead_IDEX",  64'(bus.MemRead_IDEX),  64'(m_mr));
        chk("MemWrite_IDEX", 64'(bus.MemWrite_IDEX), 64'(m_mw));
        chk("MemtoReg_IDEX", 64'(bus.MemtoReg_IDEX), 64'(m_m2r));
        chk("ALUSrc_IDEX",   64'(bus.ALUSrc_IDEX),   64'(m_as));
        chk("ALUOp_IDEX",    64'(bus.ALUOp_IDEX),    64'(m_aluop));
        chk("bubble_cnt",    64'(bus.bubble_cnt),    64'(m_cnt));
    endtask

    // Stall is expected only for an unmasked load-use hazard
    function automatic logic model_stall();
        return model_lu() && !bus.flush_EX && !bus.hold;
    endfunction

    // One clock: check stall mid-cycle, advance model, check registers after the edge
    task automatic cycle();
        @(negedge clk);
        chk("stall_IFID", 64'(bus.stall_IFID), 64'(model_stall()));
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_idle();
        bus.hold = 0; bus.flush_EX = 0; bus.valid_ID = 0;
        bus.pc_ID = 0; bus.imm_ID = 0; bus.rs1_ID = 0; bus.rs2_ID = 0; bus.rd_ID = 0;
        bus.uses_rs1_ID = 0; bus.uses_rs2_ID = 0; bus.rdata1_ID = 0; bus.rdata2_ID = 0;
        bus.RegWrite_ID = 0; bus.MemRead_ID = 0; bus.MemWrite_ID = 0;
        bus.MemtoReg_ID = 0; bus.ALUSrc_ID = 0; bus.ALUOp_ID = 0;
        bus.RegWrite_MEWB = 0; bus.rd_MEWB = 0; bus.wdata_MEWB = 0;
    endtask

    // Small register indices make hazards and bypasses frequent
    task automatic rand_inputs();
        bus.hold        = ($urandom_range(0, 7) == 0);
        bus.flush_EX    = ($urandom_range(0, 9) == 0);
        bus.valid_ID    = ($urandom_range(0, 4) != 0);
        bus.pc_ID       = $urandom;
        bus.imm_ID      = $urandom;
        bus.rs1_ID      = 5'($urandom_range(0, 3));
        bus.rs2_ID      = 5'($urandom_range(0, 3));
        bus.rd_ID       = 5'($urandom_range(0, 3));
        bus.uses_rs1_ID = 1'($urandom);
        bus.uses_rs2_ID = 1'($urandom);
        bus.rdata1_ID   = $urandom;
        bus.rdata2_ID   = $urandom;
        bus.RegWrite_ID = 1'($urandom);
        bus.MemRead_ID  = ($urandom_range(0, 2) != 0);
        bus.MemWrite_ID = 1'($urandom);
        bus.MemtoReg_ID = 1'($urandom);
        bus.ALUSrc_ID   = 1'($urandom);
        bus.ALUOp_ID    = 4'($urandom);
        bus.RegWrite_MEWB = 1'($urandom);
        bus.rd_MEWB     = 5'($urandom_range(0, 3));
        bus.wdata_MEWB  = $urandom;
    endtask

    task automatic drive_load(input logic [4:0] rd);
        set_idle();
        bus.valid_ID = 1; bus.rd_ID = rd; bus.MemRead_ID = 1;
        bus.RegWrite_ID = 1; bus.MemtoReg_ID = 1; bus.pc_ID = 32'h100;
    endtask

    task automatic drive_user(input logic [4:0] rs2);
        set_idle();
        bus.valid_ID = 1; bus.rs2_ID = rs2; bus.uses_rs2_ID = 1;
        bus.rd_ID = 5'd8; bus.RegWrite_ID = 1; bus.pc_ID = 32'h104;
    endtask

    initial begin
        // Reset with random inputs
        rst_n = 0;
        rand_inputs();
        model_reset();
        @(negedge clk);
        chk("rst_stall", 64'(bus.stall_IFID), 64'(0));
        check_all();
        @(posedge clk);
        #1;
        rand_inputs();
        #1;
        check_all();
        set_idle();
        rst_n = 1;

        // First capture after reset
        bus.valid_ID = 1; bus.rd_ID = 5'd5; bus.RegWrite_ID = 1;
        cycle();
        chk("first_rd", 64'(bus.rd_IDEX), 64'(5));
        chk("first_valid", 64'(bus.valid_IDEX), 64'(1));

        // Load-use costs exactly one bubble
        drive_load(5'd7);
        cycle();
        drive_user(5'd7);
        #1;
        chk("lu_stall", 64'(bus.stall_IFID), 64'(1));
        cycle();
        chk("lu_bubble_valid", 64'(bus.valid_IDEX), 64'(0));
        chk("lu_bubble_cnt", 64'(bus.bubble_cnt), 64'(1));
        chk("lu_released", 64'(bus.stall_IFID), 64'(0));
        cycle();
        chk("lu_dep_valid", 64'(bus.valid_IDEX), 64'(1));
        chk("lu_dep_rs2", 64'(bus.rs2_IDEX), 64'(7));

        // Load to x0 never stalls
        drive_load(5'd0);
        cycle();
        set_idle();
        bus.valid_ID = 1; bus.rs1_ID = 0; bus.uses_rs1_ID = 1;
        #1;
        chk("x0_nostall", 64'(bus.stall_IFID), 64'(0));
        cycle();

        // Matching index without a use never stalls
        drive_load(5'd4);
        cycle();
        set_idle();
        bus.valid_ID = 1; bus.rs1_ID = 5'd4; bus.rs2_ID = 5'd1; bus.uses_rs2_ID = 1;
        #1;
        chk("unused_nostall", 64'(bus.stall_IFID), 64'(0));
        cycle();

        // WB bypass into rs1 operand
        set_idle();
        bus.valid_ID = 1; bus.rs1_ID = 5'd3; bus.rdata1_ID = 32'h11;
        bus.RegWrite_MEWB = 1; bus.rd_MEWB = 5'd3; bus.wdata_MEWB = 32'hDEADBEEF;
        cycle();
        chk("bypass_hit", 64'(bus.rdata1_IDEX), 64'(32'hDEADBEEF));
        bus.rd_MEWB = 5'd0;
        cycle();
        chk("bypass_x0", 64'(bus.rdata1_IDEX), 64'(32'h11));

        // Flush together with load-use: flush wins, single count
        drive_load(5'd6);
        cycle();
        set_idle();
        bus.valid_ID = 1; bus.rs1_ID = 5'd6; bus.uses_rs1_ID = 1; bus.flush_EX = 1;
        #1;
        chk("flush_lu_stall", 64'(bus.stall_IFID), 64'(0));
        cycle();
        chk("flush_lu_valid", 64'(bus.valid_IDEX), 64'(0));
        chk("flush_lu_cnt", 64'(bus.bubble_cnt), 64'(2));

        // Hold freezes everything even with a pending flush
        set_idle();
        bus.valid_ID = 1; bus.pc_ID = 32'h1000; bus.rd_ID = 5'd9;
        cycle();
        bus.hold = 1; bus.flush_EX = 1; bus.pc_ID = 32'h2000;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("hold_pc", 64'(bus.pc_IDEX), 64'(32'h1000));
            chk("hold_rd", 64'(bus.rd_IDEX), 64'(9));
            chk("hold_cnt", 64'(bus.bubble_cnt), 64'(2));
        end
        bus.hold = 0;
        cycle();
        chk("unhold_valid", 64'(bus.valid_IDEX), 64'(0));
        chk("unhold_pc", 64'(bus.pc_IDEX), 64'(0));
        chk("unhold_cnt", 64'(bus.bubble_cnt), 64'(3));

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cycle();
        end

        // Counter saturation
        for (int i = 0; i < 20; i++) begin
            drive_load(5'd7);
            cycle();
            drive_user(5'd7);
            cycle();
        end
        chk("sat_cnt", 64'(bus.bubble_cnt), 64'(CNT_MAX));

        // Reset mid-stall releases the stall asynchronously
        drive_load(5'd7);
        cycle();
        drive_user(5'd7);
        #1;
        chk("pre_rst_stall", 64'(bus.stall_IFID), 64'(1));
        rst_n = 0;
        #1;
        chk("async_rst_stall", 64'(bus.stall_IFID), 64'(0));
        chk("async_rst_valid", 64'(bus.valid_IDEX), 64'(0));
        chk("async_rst_cnt", 64'(bus.bubble_cnt), 64'(0));
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/idex_stage.md
# idex_stage

ID/EX pipeline register with load-use hazard detection for the five-stage RISC-V core. It captures decoded operands and control from ID and holds them for EX, where the forwarding unit compares `rs1_IDEX`, `rs2_IDEX` and `RegWrite_*` against later stages. It inserts bubbles on load-use hazards and on EX flushes, and bypasses same-cycle WB writes into the ID operand values. A saturating bubble counter supports performance analysis.

## Interface
- `XLEN`, 32, datapath width
- `CNT_W`, 16, bubble counter width

Ports (ID-side inputs are `*_ID`, registered outputs are `*_IDEX`):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `hold`  in  1  global freeze (memory wait); ID/EX and counter keep their value
- `flush_EX`  in  1  taken branch/jump resolved in EX; kills the instruction currently in ID
- `valid_ID`  in  1  ID holds a real instruction
- `pc_ID`, `imm_ID`  in  XLEN  PC and immediate
- `rs1_ID`, `rs2_ID`, `rd_ID`  in  5  register indices
- `uses_rs1_ID`, `uses_rs2_ID`  in  1  instruction actually reads rs1/rs2
- `rdata1_ID`, `rdata2_ID`  in  XLEN  register-file read data
- `RegWrite_ID`, `MemRead_ID`, `MemWrite_ID`, `MemtoReg_ID`, `ALUSrc_ID`  in  1  control
- `ALUOp_ID`  in  4  ALU operation
- `RegWrite_MEWB`  in  1, `rd_MEWB`  in  5, `wdata_MEWB`  in  XLEN  WB write port (for ID bypass)
- `stall_IFID`  out  1  combinational; hold PC and IF/ID this cycle
- `valid_IDEX`, `pc_IDEX`, `imm_IDEX`, `rs1_IDEX`, `rs2_IDEX`, `rd_IDEX`, `rdata1_IDEX`, `rdata2_IDEX`, control `*_IDEX`  out  as input widths  registered copies
- `bubble_cnt`  out  CNT_W  bubbles inserted since reset

## Operation
- Load-use hazard: `lu = valid_ID & valid_IDEX & MemRead_IDEX & (rd_IDEX != 0) & ((uses_rs1_ID & rs1_ID == rd_IDEX) | (uses_rs2_ID & rs2_ID == rd_IDEX))`.
- `stall_IFID = lu & ~flush_EX & ~hold`. During `hold` the upstream stages are frozen by `hold` itself.
- WB bypass: the operand captured into `rdataN_IDEX` is `wdata_MEWB` when `RegWrite_MEWB & rd_MEWB != 0 & rd_MEWB == rsN_ID`, else `rdataN_ID`.
- Next-state priority on each edge:
  1. `hold`: all registers and `bubble_cnt` unchanged.
  2. `flush_EX`: load a bubble.
  3. `lu`: load a bubble.
  4. Otherwise: load ID values, with `valid_IDEX = valid_ID`.
- Bubble contents: `valid`, `RegWrite`, `MemRead`, `MemWrite`, `MemtoReg`, `ALUSrc`, `ALUOp`, `rd`, `rs1` and `rs2` are all 0. Data fields (`pc`, `imm`, `rdata`) are don't-care and are zeroed.
- Bubble counter:
  - `bubble_cnt` increments by 1 on every edge that loads a bubble due to `flush_EX` or `lu` with `valid_ID=1`.
  - An invalid ID slot passing through is not counted.
  - The counter saturates at 2^CNT_W−1 and does not wrap.
- `rd=0` never triggers a hazard or a bypass.

## Timing
- Reset (`rst_n`=0, async): every `*_IDEX` output is 0, `bubble_cnt` is 0, and `stall_IFID` is 0 because `valid_IDEX` is 0. Deassertion takes effect at the next rising edge.
- Latency is 1 cycle from ID inputs to `*_IDEX`.
- A load-use pair costs exactly 1 bubble:
  - Cycle N: `stall_IFID`=1.
  - Edge N+1: bubble in EX, load moves on; the dependent instruction is still in ID.
  - Cycle N+1: `lu`=0, so it advances. Forwarding then supplies the load data from MEM/WB.
- `flush_EX` together with `lu` in the same cycle: the flush wins, a bubble is loaded, `stall_IFID`=0, and the count is incremented once.
- `hold` together with `flush_EX`: the flush is not applied. The source keeps `flush_EX` asserted until `hold` drops.
- Reset asserted mid-stall clears `valid_IDEX`, so the stall releases immediately (asynchronously).

## Test plan
- Reset: drive random inputs with `rst_n`=0 -> all outputs 0 and `stall_IFID`=0. After release, one edge with `valid_ID`=1, `rd_ID`=5, `RegWrite_ID`=1 -> `rd_IDEX`=5, `valid_IDEX`=1.
- Load-use: load `rd`=x7 in ID/EX (`MemRead_IDEX`=1), ID has `rs2`=7, `uses_rs2`=1 -> `stall_IFID`=1 for exactly 1 cycle, next `valid_IDEX`=0, `bubble_cnt`=1. The following edge captures the dependent instruction.
- No false hazard:
  - load to x0 with ID rs1=0 -> `stall_IFID`=0.
  - `uses_rs1_ID`=0 with a matching index -> `stall_IFID`=0.
- WB bypass: `RegWrite_MEWB`=1, `rd_MEWB`=3, `wdata_MEWB`=0xDEADBEEF, `rs1_ID`=3, `rdata1_ID`=0x11 -> `rdata1_IDEX`=0xDEADBEEF. The same case with `rd_MEWB`=0 -> 0x11.
- Flush and hold:
  - `flush_EX` with `lu` in the same cycle -> bubble, `stall_IFID`=0, count +1.
  - `hold`=1 for 3 cycles with `flush_EX`=1 -> outputs frozen.
  - On `hold` release -> bubble loaded.
- Saturation: `CNT_W`=4, force 20 load-use bubbles -> `bubble_cnt` stays at 15.
